// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, oversampling constants and receiver FSM states.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned PAR_NONE   = 0;
    localparam int unsigned PAR_ODD    = 1;
    localparam int unsigned PAR_EVEN   = 2;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 7;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: pulses tick once every TICK_DIV clocks; clear restarts the phase.
module uart_baud_tick #(
    parameter int unsigned TICK_DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 16x oversampling UART receiver with start-bit qualification, optional parity, stop check
// and a one-entry holding register with valid/ack handshake.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 27,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = PAR_NONE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overrun_err
);

    localparam logic [3:0] S_MID  = 4'(MID_SAMPLE);
    localparam logic [3:0] S_END  = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] B_LAST = 3'(DATA_BITS - 1);

    logic       sync1_q, sync2_q;
    rx_state_e  state_q;
    logic [3:0] s_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       par_err_q;
    logic       tick;
    logic       tick_clr;
    logic       par_exp;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

    // Holding the divider clear while idle aligns the sampling phase to the start edge.
    assign tick_clr = (state_q == StIdle);
    assign par_exp  = (PARITY == PAR_EVEN) ? ^shift_q : ~(^shift_q);

    uart_baud_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(tick_clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            s_q         <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (rx_valid && rx_ack) begin
                rx_valid <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (!sync2_q) begin
                        state_q   <= StStart;
                        s_q       <= '0;
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                        par_err_q <= 1'b0;
                    end
                end
                StStart: begin
                    if (tick) begin
                        s_q <= s_q + 4'd1;
                        if (s_q == S_MID && sync2_q) begin
                            state_q <= StIdle;
                        end else if (s_q == S_END) begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        s_q <= s_q + 4'd1;
                        if (s_q == S_MID) begin
                            shift_q[bit_cnt_q] <= sync2_q;
                        end
                        if (s_q == S_END) begin
                            if (bit_cnt_q == B_LAST) begin
                                state_q <= (PARITY != PAR_NONE) ? StParity : StStop;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
                end
                StParity: begin
                    if (tick) begin
                        s_q <= s_q + 4'd1;
                        if (s_q == S_MID) begin
                            par_err_q <= (sync2_q != par_exp);
                        end
                        if (s_q == S_END) begin
                            state_q <= StStop;
                        end
                    end
                end
                StStop: begin
                    // Complete at the stop mid-sample so a following start edge is not missed.
                    if (tick && s_q == S_MID) begin
                        state_q     <= StIdle;
                        rx_data     <= shift_q;
                        parity_err  <= par_err_q;
                        framing_err <= ~sync2_q;
                        rx_valid    <= 1'b1;
                        overrun_err <= rx_valid && !rx_ack;
                    end else if (tick) begin
                        s_q <= s_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
